// File: rtl/pc_pkg.sv
// pc_pkg: next-PC select encoding and target alignment helper shared by the PC controller.
package pc_pkg;
  typedef enum logic [2:0] {SEL_HOLD, SEL_RET, SEL_SEQ, SEL_CALL, SEL_JMP, SEL_BR} pc_sel_e;
  function automatic logic [63:0] align_mask(input int addr_w, input int step);
    logic [63:0] m;
    m = ~(64'(step) - 64'd1);
    return addr_w >= 64 ? m : m & ((64'd1 << addr_w) - 64'd1);
  endfunction
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras #(
  parameter int ADDR_W = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              ovf
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0] cnt;
  assign top = mem[ptr];
  assign empty = cnt == '0;
  assign full = cnt == (PW+1)'(RAS_DEPTH);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      mem[ptr + 1'b1] <= push_data;
      cnt <= full ? cnt : cnt + 1'b1;
      ovf <= ovf | full;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage program counter with stall, prioritised redirects and a return-address stack.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int STEP = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              call_valid,
  input  logic [ADDR_W-1:0] call_target,
  input  logic              ret_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus_step,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(align_mask(ADDR_W, STEP));
  pc_sel_e sel;
  logic [ADDR_W-1:0] pc_nxt, ras_top;
  logic unf_nxt;
  assign pc_plus_step = pc_out + ADDR_W'(STEP);
  // A return on an empty stack falls through to the sequential path and flags underflow.
  always_comb begin
    sel = stall ? SEL_HOLD : ret_valid ? (ras_empty ? SEL_SEQ : SEL_RET) :
          call_valid ? SEL_CALL : jmp_valid ? SEL_JMP : br_valid ? SEL_BR : SEL_SEQ;
    unf_nxt = !stall && ret_valid && ras_empty;
    pc_nxt = sel == SEL_HOLD ? pc_out :
             sel == SEL_RET  ? ras_top :
             sel == SEL_CALL ? call_target & MASK :
             sel == SEL_JMP  ? jmp_target & MASK :
             sel == SEL_BR   ? br_target & MASK : pc_plus_step;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_out <= RESET_VEC;
      ras_unf <= 1'b0;
    end else begin
      pc_out <= pc_nxt;
      ras_unf <= unf_nxt;
    end
  end
  pc_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .rst_n(rst_n),
    .push(sel == SEL_CALL),
    .pop(sel == SEL_RET),
    .push_data(pc_plus_step),
    .top(ras_top),
    .empty(ras_empty),
    .full(ras_full),
    .ovf(ras_ovf)
  );
endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Parametrised program-counter controller. It is the next generation of the fixed 32-bit program counter.
- Generalises address width and increment step.
- Adds a stall input, a prioritised redirect (branch / jump / call / return) and a return-address stack (RAS) of configurable depth.
- Sits at the front of the fetch stage. Drives instruction-memory address and the sequential-next address to decode.

Parameters:
ADDR_W, 32, PC and target width in bits
STEP, 4, sequential increment in bytes (power of two, at least 1)
RESET_VEC, 0, PC value loaded on reset
RAS_DEPTH, 4, return-address stack entries (power of two, at least 2)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
stall  in  1  hold PC and RAS this cycle
br_valid  in  1  taken conditional branch
br_target  in  ADDR_W  branch target
jmp_valid  in  1  unconditional jump
jmp_target  in  ADDR_W  jump target
call_valid  in  1  call: jump to call_target and push return address
call_target  in  ADDR_W  call target
ret_valid  in  1  return: pop RAS into PC
pc_out  out  ADDR_W  current PC, registered
pc_plus_step  out  ADDR_W  pc_out + STEP, combinational, modulo 2^ADDR_W
ras_empty  out  1  RAS holds no entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_ovf  out  1  sticky: a push occurred while full
ras_unf  out  1  one-cycle pulse: ret_valid while empty, not stalled

Behaviour:
Reset:
- Reset is synchronous: rst_n low at a rising clk edge forces pc_out=RESET_VEC, RAS count=0, RAS pointers=0, ras_ovf=0, ras_unf=0.
- Hence ras_empty=1 and ras_full=0 after reset.
- Reset overrides every other input, including mid-redirect and mid-stall.

Next-PC selection (per edge, rst_n high), highest priority first:
1. stall=1: pc_out, RAS and ras_ovf hold; ras_unf=0. All redirect inputs are ignored and not remembered.
2. ret_valid and RAS not empty: pc_out <= top entry; pop; count decrements.
3. ret_valid and RAS empty: pc_out <= pc_plus_step; ras_unf=1 for exactly that cycle.
4. call_valid: pc_out <= call_target; push pc_plus_step; count increments, saturating at RAS_DEPTH.
5. jmp_valid: pc_out <= jmp_target.
6. br_valid: pc_out <= br_target.
7. Otherwise: pc_out <= pc_plus_step.

Timing and arithmetic:
- Latency is one cycle. A redirect sampled at edge k appears on pc_out after edge k. There are no bubbles.
- All targets are force-aligned: the low log2(STEP) bits are cleared before loading. Pushed return addresses are aligned by construction.
- Sequential increment wraps: pc_out=2^ADDR_W-STEP is followed by 0.

RAS:
- Circular buffer with a top pointer and a count.
- Push when full overwrites the oldest entry. Count stays at RAS_DEPTH, ras_ovf is set and stays 1 until reset.
- Simultaneous call_valid and ret_valid: ret wins, there is no push, and call_target is ignored.
- ras_unf is 0 in every cycle other than case 3.

Decomposition:
- Shared package pc_pkg: the next-PC select encoding (SEL_HOLD, SEL_RET, SEL_SEQ, SEL_CALL, SEL_JMP, SEL_BR) and an alignment-mask function of ADDR_W and STEP.
- One sub-module, pc_ras: parametrised by ADDR_W and RAS_DEPTH, with push, pop, top, empty, full and ovf. pc_ctrl holds the PC register and the priority mux.

Test Plan:
- Reset and sequential: rst_n=0 for 2 cycles, then release with no inputs -> pc_out = 0, 4, 8, 12 on successive cycles; ras_empty=1.
- Priority and alignment: at pc_out=0x10, assert br_valid (target 0x100) and jmp_valid (target 0x203) together -> next pc_out=0x200. Then stall=1 for 3 cycles with br_valid=1 -> pc_out stays 0x200, then advances to 0x204.
- Call/return: at pc_out=0x40, call to 0x400 -> pc_out=0x400, RAS count=1. Run 2 sequential cycles (0x404, 0x408). Then ret_valid -> pc_out=0x44 and ras_empty=1.
- Overflow: RAS_DEPTH=4, five nested calls from 0x0, 0x100, 0x200, 0x300, 0x400 -> ras_full=1 and ras_ovf=1 after the fifth call. Four returns yield 0x404, 0x304, 0x204, 0x104, then ras_empty=1.
- Underflow and simultaneous: ret_valid with empty RAS at pc_out=0x80 -> pc_out=0x84 and ras_unf high for one cycle. Then call (target 0x500) and ret asserted together with one entry 0x44 -> pc_out=0x44 and no push.
- Wrap and mid-operation reset: ADDR_W=8, STEP=4, from pc_out=0xFC -> next pc_out=0x00. Assert rst_n=0 in the same cycle as call_valid -> pc_out=RESET_VEC, ras_empty=1, ras_ovf=0.
